// File: rtl/mips_bridge_pkg.sv
// Shared types and defaults for the CPU data-port stall bridge.
// Holds the bridge FSM encoding and the timeout and error-data defaults.
package mips_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } bridge_state_t;

  localparam int          DEFAULT_TIMEOUT_CYCLES = 64;
  localparam logic [31:0] DEFAULT_ERR_DATA       = 32'hDEADBEEF;

endpackage

// File: rtl/bridge_timeout_ctr.sv
// Counts cycles spent waiting on the RAM; expired is combinational and fires on the TIMEOUT_CYCLES-th counted cycle.
// Saturates at the limit, so expired stays high if the owner is still counting; clear wins over count_en.
module bridge_timeout_ctr
  import mips_bridge_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST  = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (count_en && (cnt != LIMIT)) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expired = count_en && (cnt >= LAST);

endmodule

// File: rtl/mips_data_stall_bridge.sv
// Turns single-cycle CPU data accesses into req/ready/rvalid RAM transactions, freezing the CPU via clk_enable.
// Read commits 3 cycles after the strobe (ready=1, rvalid +1), write 2; RAM backpressure stretches the stall, capped by the timeout.
module mips_data_stall_bridge
  import mips_bridge_pkg::*;
#(
  parameter int          ADDR_W         = 30,
  parameter int          TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter logic [31:0] ERR_DATA       = DEFAULT_ERR_DATA
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  output logic              clk_enable,
  input  logic [31:0]       cpu_data_address,
  input  logic              cpu_data_read,
  input  logic              cpu_data_write,
  input  logic [31:0]       cpu_data_writedata,
  output logic [31:0]       cpu_data_readdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic              bus_error
);

  bridge_state_t state, state_next;

  logic issue;
  logic rd_latch;
  logic err_latch;
  logic err_set;
  logic expired;
  logic strobe;
  logic unused_addr_lsbs;

  assign strobe           = cpu_data_read || cpu_data_write;
  assign unused_addr_lsbs = ^cpu_data_address[1:0];

  assign clk_enable = run && (((state == IDLE) && !strobe) || (state == DONE));
  assign mem_req    = (state == REQ);

  bridge_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .clear    (state == IDLE),
    .count_en ((state == REQ) || (state == WAIT)),
    .expired  (expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A real RAM response always beats a timeout landing in the same cycle.
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    rd_latch   = 1'b0;
    err_latch  = 1'b0;
    err_set    = 1'b0;
    case (state)
      IDLE: begin
        if (strobe) begin
          issue      = 1'b1;
          state_next = REQ;
          if (cpu_data_read && cpu_data_write) err_set = 1'b1;
        end
        if (mem_rvalid) err_set = 1'b1;
      end
      REQ: begin
        if (mem_ready) begin
          if (mem_we) begin
            state_next = DONE;
            if (mem_rvalid) err_set = 1'b1;
          end else if (mem_rvalid) begin
            rd_latch   = 1'b1;
            state_next = DONE;
          end else begin
            state_next = WAIT;
          end
        end else begin
          if (mem_rvalid) err_set = 1'b1;
          if (expired) begin
            state_next = DONE;
            err_set    = 1'b1;
            err_latch  = !mem_we;
          end
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          rd_latch   = 1'b1;
          state_next = DONE;
        end else if (expired) begin
          state_next = DONE;
          err_set    = 1'b1;
          err_latch  = 1'b1;
        end
      end
      DONE: begin
        if (run) state_next = IDLE;
        if (mem_rvalid) err_set = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_we            <= 1'b0;
      mem_addr          <= '0;
      mem_wdata         <= '0;
      cpu_data_readdata <= '0;
      bus_error         <= 1'b0;
    end else begin
      if (issue) begin
        mem_we    <= cpu_data_write;
        mem_addr  <= cpu_data_address[ADDR_W+1:2];
        mem_wdata <= cpu_data_writedata;
      end
      if (rd_latch) begin
        cpu_data_readdata <= mem_rdata;
      end else if (err_latch) begin
        cpu_data_readdata <= ERR_DATA;
      end
      if (err_set) bus_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mips_data_stall_bridge.sv
// Bench for mips_data_stall_bridge: table-driven CPU accesses against a scripted RAM responder.
// Expected RAM requests are queued at drive time and retired when the responder accepts them.
module tb_mips_data_stall_bridge;

  logic        clk;
  logic        reset;
  logic        run;
  logic        clk_enable;
  logic [31:0] cpu_data_address;
  logic        cpu_data_read;
  logic        cpu_data_write;
  logic [31:0] cpu_data_writedata;
  logic [31:0] cpu_data_readdata;
  logic        mem_req;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        bus_error;

  mips_data_stall_bridge dut (
    .clk                (clk),
    .reset              (reset),
    .run                (run),
    .clk_enable         (clk_enable),
    .cpu_data_address   (cpu_data_address),
    .cpu_data_read      (cpu_data_read),
    .cpu_data_write     (cpu_data_write),
    .cpu_data_writedata (cpu_data_writedata),
    .cpu_data_readdata  (cpu_data_readdata),
    .mem_req            (mem_req),
    .mem_we             (mem_we),
    .mem_addr           (mem_addr),
    .mem_wdata          (mem_wdata),
    .mem_ready          (mem_ready),
    .mem_rvalid         (mem_rvalid),
    .mem_rdata          (mem_rdata),
    .bus_error          (bus_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [29:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    bit          rd;
    bit          wr;
    bit          silent;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          rdy;
    int          rv;
    logic [29:0] exp_maddr;
    int          exp_stall;
    int          exp_req_cycles;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  req_t        exp_req_q[$];
  logic [31:0] exp_rd_q[$];

  int checks = 0;
  int errors = 0;

  int          resp_rdy    = 0;
  int          resp_rv     = 0;
  logic [31:0] resp_rdata  = '0;
  bit          resp_silent = 1'b0;
  int          req_cycles  = 0;
  int          writes_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Scripted RAM: ready after resp_rdy request cycles, rvalid resp_rv cycles after acceptance.
  initial begin
    int req_age;
    int rv_cnt;
    req_t head;
    req_age    = 0;
    rv_cnt     = 0;
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    forever begin
      @(negedge clk);
      mem_ready  = 1'b0;
      mem_rvalid = 1'b0;
      if (rv_cnt == 1) begin
        mem_rvalid = 1'b1;
        mem_rdata  = resp_rdata;
        rv_cnt     = 0;
      end else if (rv_cnt > 1) begin
        rv_cnt--;
      end
      if (mem_req === 1'b1) begin
        req_cycles++;
        if (exp_req_q.size() > 0) begin
          head = exp_req_q[0];
          check("req_we", 32'(mem_we), 32'(head.we));
          check("req_addr", 32'(mem_addr), 32'(head.addr));
          if (head.we) check("req_wdata", mem_wdata, head.wdata);
        end
        if (!resp_silent && req_age == resp_rdy) begin
          mem_ready = 1'b1;
          if (exp_req_q.size() > 0) begin
            void'(exp_req_q.pop_front());
          end else begin
            checks++;
            errors++;
            $display("FAIL unexpected_req actual=handshake required=none addr=%h", mem_addr);
          end
          if (mem_we) begin
            writes_seen++;
          end else if (resp_rv == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = resp_rdata;
          end else begin
            rv_cnt = resp_rv;
          end
        end
        req_age++;
      end else begin
        req_age = 0;
      end
    end
  end

  task automatic do_access(input vec_t v, input string tag);
    int stall;
    @(negedge clk);
    resp_rdy    = v.rdy;
    resp_rv     = v.rv;
    resp_rdata  = v.rdata;
    resp_silent = v.silent;
    req_cycles  = 0;
    if (!v.silent) exp_req_q.push_back('{we: v.wr, addr: v.exp_maddr, wdata: v.wdata});
    exp_rd_q.push_back(v.exp_rdata);
    cpu_data_read      = v.rd;
    cpu_data_write     = v.wr;
    cpu_data_address   = v.addr;
    cpu_data_writedata = v.wdata;
    stall = 0;
    #1;
    while (clk_enable !== 1'b1 && stall < 200) begin
      stall++;
      @(negedge clk);
      #1;
    end
    check({tag, "_stall"}, 32'(stall), 32'(v.exp_stall));
    check({tag, "_rdata"}, cpu_data_readdata, exp_rd_q.pop_front());
    check({tag, "_err"}, 32'(bus_error), 32'(v.exp_err));
    check({tag, "_req_cycles"}, 32'(req_cycles), 32'(v.exp_req_cycles));
    @(negedge clk);
    cpu_data_read  = 1'b0;
    cpu_data_write = 1'b0;
    @(negedge clk);
    #1;
    check({tag, "_idle_no_req"}, 32'(mem_req), 32'd0);
    check({tag, "_idle_ce"}, 32'(clk_enable), 32'd1);
  endtask

  vec_t tbl[5];
  vec_t v;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset              = 1'b1;
    run                = 1'b1;
    cpu_data_address   = '0;
    cpu_data_read      = 1'b0;
    cpu_data_write     = 1'b0;
    cpu_data_writedata = '0;

    // rd wr silent addr wdata rdata rdy rv maddr stall reqcyc exp_rdata err
    tbl[0] = '{1'b1, 1'b0, 1'b0, 32'h00000104, 32'h0, 32'h12345678, 0, 1, 30'h41, 3, 1, 32'h12345678, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 32'h00000200, 32'hCAFEF00D, 32'h0, 3, 0, 30'h80, 5, 4, 32'h12345678, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 32'h000003FC, 32'h0, 32'hA5A50F0F, 0, 0, 30'hFF, 2, 1, 32'hA5A50F0F, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 32'h00000010, 32'h0, 32'h0BADF00D, 2, 3, 30'h4, 7, 3, 32'h0BADF00D, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 32'hFFFFFFFF, 32'h13579BDF, 32'h0, 0, 0, 30'h3FFFFFFF, 2, 1, 32'h0BADF00D, 1'b0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_readdata", cpu_data_readdata, 32'd0);
    check("rst_bus_error", 32'(bus_error), 32'd0);
    check("rst_clk_enable", 32'(clk_enable), 32'd1);

    for (int i = 0; i < 5; i++) begin
      do_access(tbl[i], $sformatf("vec%0d", i));
    end

    // run dropped while waiting for read data: park in DONE, commit once run returns.
    @(negedge clk);
    resp_rdy = 0; resp_rv = 1; resp_rdata = 32'h55AA55AA; resp_silent = 1'b0;
    exp_req_q.push_back('{we: 1'b0, addr: 30'hAA, wdata: 32'h0});
    cpu_data_read    = 1'b1;
    cpu_data_address = 32'h000002A8;
    @(negedge clk);
    @(negedge clk);
    run = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      check("park_ce", 32'(clk_enable), 32'd0);
      check("park_no_req", 32'(mem_req), 32'd0);
    end
    @(negedge clk);
    run = 1'b1;
    #1;
    check("park_commit_ce", 32'(clk_enable), 32'd1);
    check("park_commit_rdata", cpu_data_readdata, 32'h55AA55AA);
    @(negedge clk);
    cpu_data_read = 1'b0;
    #1;
    check("park_idle_ce", 32'(clk_enable), 32'd1);
    check("park_idle_no_req", 32'(mem_req), 32'd0);

    // Both strobes: issued as a write and flagged.
    v = '{1'b1, 1'b1, 1'b0, 32'h00000040, 32'h11112222, 32'h0, 0, 0, 30'h10, 2, 1, 32'h55AA55AA, 1'b1};
    do_access(v, "both");

    // Reset while the request is outstanding.
    @(negedge clk);
    resp_silent      = 1'b1;
    cpu_data_read    = 1'b1;
    cpu_data_address = 32'h00000600;
    @(negedge clk);
    #1;
    check("midrst_req_before", 32'(mem_req), 32'd1);
    reset         = 1'b1;
    cpu_data_read = 1'b0;
    @(negedge clk);
    #1;
    check("midrst_mem_req", 32'(mem_req), 32'd0);
    check("midrst_readdata", cpu_data_readdata, 32'd0);
    check("midrst_bus_error", 32'(bus_error), 32'd0);
    check("midrst_idle_ce", 32'(clk_enable), 32'd1);
    reset = 1'b0;

    // RAM never answers: abandon after 64 cycles with error data.
    v = '{1'b1, 1'b0, 1'b1, 32'h00000500, 32'h0, 32'h0, 0, 0, 30'h140, 65, 64, 32'hDEADBEEF, 1'b1};
    do_access(v, "timeout");
    repeat (3) @(negedge clk);
    #1;
    check("timeout_err_sticky", 32'(bus_error), 32'd1);
    v = '{1'b0, 1'b1, 1'b0, 32'h00000008, 32'h0F0F0F0F, 32'h0, 1, 0, 30'h2, 3, 2, 32'hDEADBEEF, 1'b1};
    do_access(v, "post_timeout");

    check("writes_seen", 32'(writes_seen), 32'd4);
    check("req_queue_empty", 32'(exp_req_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
